// File: rtl/wb_calc_e_master.sv
// wb_calc_e_master: Wishbone classic initiator for the calc_e register slave.
// Takes a sequence word on a valid/ready stream and returns E on an output stream.
module wb_calc_e_master #(
    parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
    parameter int          SEQ_WIDTH   = 8,
    parameter int          E_WIDTH     = 16,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n,
    input  logic                 i_cfg,
    input  logic [6:0]           i_offset,
    input  logic                 i_soft_rst,
    input  logic [SEQ_WIDTH-1:0] i_seq,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [E_WIDTH-1:0]   o_e,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_busy,
    output logic                 o_err,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [3:0]           wbm_sel_o,
    output logic [31:0]          wbm_adr_o,
    output logic [31:0]          wbm_dat_o,
    input  logic [31:0]          wbm_dat_i,
    input  logic                 wbm_ack_i
);

    localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    localparam logic [31:0] ADR_CTRL   = BASE_ADR;
    localparam logic [31:0] ADR_STATUS = BASE_ADR + 32'h4;
    localparam logic [31:0] ADR_SEQ    = BASE_ADR + 32'h8;
    localparam logic [31:0] ADR_E      = BASE_ADR + 32'hC;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        POLL_IN,
        WR_SEQ,
        POLL_OUT,
        RD_E,
        OUT
    } state_t;

    state_t               state_q, state_d;
    logic                 cyc_q, cyc_d;
    logic                 stb_q, stb_d;
    logic                 we_q, we_d;
    logic [31:0]          adr_q, adr_d;
    logic [31:0]          dat_q, dat_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 pass_q, pass_d;
    logic [E_WIDTH-1:0]   e_q, e_d;
    logic                 err_q, err_d;
    logic [SEQ_WIDTH-1:0] seq_q, seq_d;
    logic                 launch;
    logic                 dat_unused;

    assign dat_unused = &{1'b0, wbm_dat_i};

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        e_d     = e_q;
        err_d   = err_q;
        seq_d   = seq_q;
        launch  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_cfg) begin
                    err_d   = 1'b0;
                    state_d = CFG;
                    launch  = 1'b1;
                end else if (i_valid) begin
                    seq_d   = i_seq;
                    state_d = POLL_IN;
                    launch  = 1'b1;
                end
            end
            OUT: begin
                if (i_ready) state_d = IDLE;
            end
            default: begin
                if (stb_q) begin
                    if (wbm_ack_i) begin
                        cyc_d = 1'b0;
                        stb_d = 1'b0;
                        case (state_q)
                            CFG:      state_d = IDLE;
                            POLL_IN:  pass_d  = wbm_dat_i[0];
                            POLL_OUT: pass_d  = wbm_dat_i[1];
                            RD_E: begin
                                e_d     = wbm_dat_i[E_WIDTH-1:0];
                                state_d = OUT;
                            end
                            default: pass_d = 1'b1;
                        endcase
                    end else if (cnt_q == CNT_LAST) begin
                        // slave never answered: abandon this run
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        err_d   = 1'b1;
                        seq_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // idle bus gap after ack; pick the next transaction
                    case (state_q)
                        POLL_IN:  state_d = pass_q ? WR_SEQ : POLL_IN;
                        WR_SEQ:   state_d = POLL_OUT;
                        POLL_OUT: state_d = pass_q ? RD_E : POLL_OUT;
                        default:  state_d = IDLE;
                    endcase
                    launch = (state_d != IDLE);
                end
            end
        endcase

        if (launch) begin
            cyc_d = 1'b1;
            stb_d = 1'b1;
            cnt_d = '0;
            we_d  = 1'b0;
            dat_d = '0;
            case (state_d)
                CFG: begin
                    adr_d       = ADR_CTRL;
                    we_d        = 1'b1;
                    dat_d[14:8] = i_offset;
                    dat_d[0]    = i_soft_rst;
                end
                WR_SEQ: begin
                    adr_d                  = ADR_SEQ;
                    we_d                   = 1'b1;
                    dat_d[SEQ_WIDTH-1:0]   = seq_q;
                end
                RD_E:    adr_d = ADR_E;
                default: adr_d = ADR_STATUS;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            e_q     <= '0;
            err_q   <= 1'b0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            e_q     <= e_d;
            err_q   <= err_d;
            seq_q   <= seq_d;
        end
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = {4{stb_q}};
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign o_ready   = (state_q == IDLE);
    assign o_busy    = (state_q != IDLE);
    assign o_valid   = (state_q == OUT);
    assign o_e       = e_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_wb_calc_e_master.sv
// tb_wb_calc_e_master: randomized sequence runs against a behavioural calc_e
// slave; bus transactions, latency and results compared with a reference.
module tb_wb_calc_e_master;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int SW = 8;
    localparam int EW = 16;
    localparam int TO = 10;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_cfg = 1'b0;
    logic [6:0]    i_offset = '0;
    logic          i_soft_rst = 1'b0;
    logic [SW-1:0] i_seq = '0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [EW-1:0] o_e;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic          o_busy;
    logic          o_err;
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_we_o;
    logic [3:0]    wbm_sel_o;
    logic [31:0]   wbm_adr_o;
    logic [31:0]   wbm_dat_o;
    logic [31:0]   wbm_dat_i = '0;
    logic          wbm_ack_i = 1'b0;

    wb_calc_e_master #(
        .BASE_ADR(BASE),
        .SEQ_WIDTH(SW),
        .E_WIDTH(EW),
        .ACK_TIMEOUT(TO)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_n(rst_n),
        .i_cfg(i_cfg),
        .i_offset(i_offset),
        .i_soft_rst(i_soft_rst),
        .i_seq(i_seq),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_e(o_e),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_busy(o_busy),
        .o_err(o_err),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [95:0] got,
                         input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave model: STATUS not-ready counts, wait states, optional stuck SEQ write
    int          in_block = 0;
    int          out_block = 0;
    int          ws = 0;
    int          n_stb = 0;
    int          last_len = 0;
    bit          phase_out = 1'b0;
    bit          no_ack_seq = 1'b0;
    logic [31:0] result = '0;
    logic [31:0] a0 = '0;
    logic [31:0] d0 = '0;
    logic        w0 = 1'b0;
    logic [31:0] rdat;
    txn_t        log_q[$];

    always @(negedge clk) begin
        if (wbm_cyc_o && wbm_stb_o) begin
            n_stb++;
            if (n_stb == 1) begin
                a0 = wbm_adr_o;
                d0 = wbm_dat_o;
                w0 = wbm_we_o;
            end else begin
                check("bus_hold", {wbm_adr_o, wbm_dat_o, wbm_we_o}, {a0, d0, w0});
            end
            check("sel", wbm_sel_o, 4'hF);
            if (n_stb == 2 + ws && !(no_ack_seq && wbm_adr_o == BASE + 32'h8)) begin
                rdat = $urandom;
                if (wbm_adr_o == BASE + 32'h4) begin
                    if (!phase_out) begin
                        rdat[0] = (in_block == 0);
                        if (in_block > 0) in_block--;
                    end else begin
                        rdat[1] = (out_block == 0);
                        if (out_block > 0) out_block--;
                    end
                end else if (wbm_adr_o == BASE + 32'h8) begin
                    phase_out = 1'b1;
                end else if (wbm_adr_o == BASE + 32'hC) begin
                    rdat = result;
                end
                wbm_ack_i = 1'b1;
                wbm_dat_i = rdat;
                log_q.push_back('{wbm_we_o, wbm_adr_o, wbm_we_o ? wbm_dat_o : 32'h0});
            end else begin
                wbm_ack_i = 1'b0;
                wbm_dat_i = $urandom;
            end
        end else begin
            if (n_stb != 0) last_len = n_stb;
            n_stb     = 0;
            wbm_ack_i = 1'b0;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_cyc"}, wbm_cyc_o, 1'b0);
        check({tag, "_stb"}, wbm_stb_o, 1'b0);
        check({tag, "_we"}, wbm_we_o, 1'b0);
        check({tag, "_sel"}, wbm_sel_o, 4'h0);
        check({tag, "_adr"}, wbm_adr_o, 32'h0);
        check({tag, "_dat"}, wbm_dat_o, 32'h0);
        check({tag, "_ready"}, o_ready, 1'b1);
        check({tag, "_valid"}, o_valid, 1'b0);
        check({tag, "_e"}, o_e, '0);
        check({tag, "_busy"}, o_busy, 1'b0);
        check({tag, "_err"}, o_err, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (o_busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(tag, o_busy, 1'b0);
    endtask

    // One sequence: k/m not-ready polls, w wait states, bp backpressure cycles
    task automatic run_seq(input logic [SW-1:0] seq, input int k, input int m,
                           input int w, input int bp, input logic [31:0] res,
                           input bit with_cfg);
        txn_t exp_q[$];
        int   lat;
        int   t;
        in_block  = k;
        out_block = m;
        ws        = w;
        phase_out = 1'b0;
        result    = res;
        log_q.delete();
        if (with_cfg) exp_q.push_back('{1'b1, BASE, 32'h0000_0A00});
        for (int i = 0; i <= k; i++) exp_q.push_back('{1'b0, BASE + 32'h4, 32'h0});
        exp_q.push_back('{1'b1, BASE + 32'h8, {24'h0, seq}});
        for (int i = 0; i <= m; i++) exp_q.push_back('{1'b0, BASE + 32'h4, 32'h0});
        exp_q.push_back('{1'b0, BASE + 32'hC, 32'h0});

        i_seq   = seq;
        i_valid = 1'b1;
        if (with_cfg) begin
            i_cfg      = 1'b1;
            i_offset   = 7'd10;
            i_soft_rst = 1'b0;
            @(negedge clk);
            i_cfg = 1'b0;
            check("cfg_wins", o_busy, 1'b1);
        end
        t = 0;
        while (!o_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("accept_ready", o_ready, 1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) i_valid = 1'b0;
        end while (!o_valid && lat < 400);
        check("out_valid", o_valid, 1'b1);
        check("latency", lat, (k + m + 4) * (3 + w));
        check("o_e", o_e, res[EW-1:0]);
        check("txn_count", log_q.size(), exp_q.size());
        foreach (exp_q[i])
            check("txn", (i < log_q.size()) ? log_q[i] : txn_t'(0), exp_q[i]);

        for (int i = 0; i < bp; i++) begin
            i_valid = 1'b1;
            i_seq   = ~seq;
            check("bp_valid", o_valid, 1'b1);
            check("bp_e", o_e, res[EW-1:0]);
            check("bp_refuse", o_ready, 1'b0);
            @(negedge clk);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        check("xfer_valid", o_valid, 1'b1);
        check("xfer_e", o_e, res[EW-1:0]);
        @(negedge clk);
        i_ready = 1'b0;
        check("valid_drop", o_valid, 1'b0);
        check("back_idle", o_ready, 1'b1);
    endtask

    initial begin
        int  t;
        bit  saw_valid;

        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("idle");

        log_q.delete();
        i_cfg      = 1'b1;
        i_offset   = 7'd5;
        i_soft_rst = 1'b0;
        @(negedge clk);
        i_cfg = 1'b0;
        wait_idle("cfg_done");
        check("cfg_count", log_q.size(), 1);
        check("cfg_txn", (log_q.size() > 0) ? log_q[0] : txn_t'(0),
              {1'b1, BASE, 32'h0000_0500});

        run_seq(8'hA5, 0, 0, 0, 0, 32'h0000_1234, 1'b0);
        run_seq(8'h3E, 3, 0, 0, 0, $urandom, 1'b0);
        run_seq(8'h81, 0, 1, 1, 5, $urandom, 1'b0);
        run_seq(8'h17, 1, 0, 0, 0, $urandom, 1'b1);

        in_block   = 1;
        out_block  = 0;
        ws         = 0;
        phase_out  = 1'b0;
        no_ack_seq = 1'b1;
        saw_valid  = 1'b0;
        i_seq      = 8'h3C;
        i_valid    = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        t = 0;
        while (o_busy && t < 300) begin
            @(negedge clk);
            saw_valid |= o_valid;
            t++;
        end
        check("to_idle", o_busy, 1'b0);
        check("to_err", o_err, 1'b1);
        check("to_ready", o_ready, 1'b1);
        check("to_no_valid", saw_valid, 1'b0);
        check("to_cyc", wbm_cyc_o, 1'b0);
        @(negedge clk);
        check("to_stb_len", last_len, TO);
        no_ack_seq = 1'b0;
        repeat (2) @(negedge clk);
        check("err_sticky", o_err, 1'b1);
        log_q.delete();
        i_cfg      = 1'b1;
        i_offset   = 7'h7F;
        i_soft_rst = 1'b1;
        @(negedge clk);
        i_cfg = 1'b0;
        check("err_clear", o_err, 1'b0);
        wait_idle("cfg2_done");
        check("cfg2_txn", (log_q.size() > 0) ? log_q[0] : txn_t'(0),
              {1'b1, BASE, 32'h0000_7F01});

        in_block  = 0;
        out_block = 1000;
        ws        = 1;
        phase_out = 1'b0;
        i_seq     = 8'h5A;
        i_valid   = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        t = 0;
        while (!(phase_out && wbm_stb_o && wbm_adr_o == BASE + 32'h4) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("poll_out_reached", wbm_stb_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("post_rst");
        run_seq(8'hC3, 0, 0, 0, 0, $urandom, 1'b0);

        for (int n = 0; n < 30; n++) begin
            run_seq(SW'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 3), $urandom, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_calc_e_master.md
# wb_calc_e_master

Wishbone classic initiator that drives the calc_e Wishbone register slave from a local valid/ready stream. It accepts a sequence word and issues the Wishbone cycles to configure, load, poll and read the slave. It returns the E result on an output stream. It sits in the test/host-side logic, where it lets on-chip logic exercise the calc_e slave without the management core.

## Interface
- BASE_ADR, 32'h3000_0000, slave base address
- SEQ_WIDTH, 8, sequence width, 1..32
- E_WIDTH, 16, result width, 1..32
- ACK_TIMEOUT, 255, maximum cycles to wait for ack, >=1

- wb_clk_i  in  1  clock
- wb_rst_n  in  1  reset, asynchronous, active-low
- i_cfg  in  1  one-cycle pulse: write CTRL with i_offset and i_soft_rst
- i_offset  in  7  offset field for CTRL
- i_soft_rst  in  1  soft-reset bit for CTRL
- i_seq  in  SEQ_WIDTH  input sequence
- i_valid  in  1  i_seq valid
- o_ready  out  1  block ready for i_seq
- o_e  out  E_WIDTH  result
- o_valid  out  1  o_e valid
- i_ready  in  1  consumer ready
- o_busy  out  1  not in IDLE
- o_err  out  1  sticky ack-timeout flag, cleared by i_cfg
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone strobes
- wbm_sel_o  out  4  byte select, always 4'hF when stb is high
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  acknowledge

## Operation
Register map (word offsets from BASE_ADR):
- +0x00 CTRL: bit0 soft reset, bits[14:8] offset.
- +0x04 STATUS: bit0 = slave ready for a sequence, bit1 = result valid.
- +0x08 SEQ: write only, bits[SEQ_WIDTH-1:0].
- +0x0C E: read only, bits[E_WIDTH-1:0]. Reading E pops the result.

FSM states: IDLE, CFG, POLL_IN, WR_SEQ, POLL_OUT, RD_E, OUT.
- IDLE:
  - o_ready=1.
  - i_cfg has priority. On i_cfg, latch {i_soft_rst, i_offset}, clear o_err, go to CFG.
  - Otherwise, on i_valid, latch i_seq and go to POLL_IN.
- CFG: write CTRL, then go to IDLE.
- POLL_IN: read STATUS.
  - If bit0=1, go to WR_SEQ.
  - If bit0=0, repeat the read after a 1-cycle gap.
- WR_SEQ: write SEQ, zero-extended, then go to POLL_OUT.
- POLL_OUT: read STATUS.
  - If bit1=1, go to RD_E.
  - If bit1=0, repeat the read.
- RD_E: read E, capture wbm_dat_i[E_WIDTH-1:0] into o_e, then go to OUT.
- OUT:
  - o_valid=1 with o_e held stable.
  - On i_ready, go to IDLE.
- Timeout: the ack counter counts cycles with stb=1 and ack=0. When it reaches ACK_TIMEOUT:
  - drop cyc/stb;
  - set o_err;
  - discard the latched sequence;
  - go to IDLE.
- Reset: asynchronous assertion forces IDLE and clears all registers, including a cycle in flight. Release is synchronous to wb_clk_i.
- Reset values:
  - cyc=stb=we=0, sel=0, adr=0, dat_o=0;
  - o_ready=1, o_valid=0, o_e=0, o_busy=0, o_err=0.

## Timing
- Each bus state asserts cyc, stb, adr, we and dat_o from a register in the first cycle of the state.
- These signals are held constant until ack is sampled high. cyc/stb are low in the cycle after ack.
- At least 1 idle bus cycle separates transactions.
- ack while stb=0 is ignored.
- Read data is sampled in the ack cycle.
- i_seq handshake: i_seq is captured in the cycle where i_valid & o_ready.
- o_ready is 0 from the next cycle until the return to IDLE.
- Output handshake: the result is transferred in the cycle where o_valid & i_ready, and o_valid drops the next cycle.
- A new i_valid is accepted no earlier than the cycle after the return to IDLE.
- Minimum latency with a zero-wait slave (ack in the 2nd stb cycle) and both polls passing first time: 4 transactions × (2 + 1 gap) = 12 cycles from accept to o_valid.
- i_cfg outside IDLE is ignored; no queuing.
- i_cfg and i_valid in the same cycle: i_cfg wins, and i_valid stays pending to the source.
- Polling has no limit. Only an individual cycle times out.

## Test plan
- Zero-wait slave model, offset 7'd5 via i_cfg:
  - CTRL write carries dat_o=32'h0000_0500 at adr 32'h3000_0000.
  - Then seq 8'hA5 produces writes/reads at 0x04, 0x08 (dat 32'h0000_00A5), 0x04, 0x0C.
  - The read returning 32'h0000_1234 gives o_e=16'h1234, with o_valid 12 cycles after accept.
- Slave STATUS bit0=0 for 3 polls: exactly 4 STATUS reads occur before the SEQ write, and bus signals stay stable while ack is low.
- Slave never acks the SEQ write with ACK_TIMEOUT=10:
  - stb drops after 10 cycles;
  - o_err=1, o_busy=0, o_ready=1, no o_valid;
  - a following i_cfg clears o_err.
- Backpressure: i_ready=0 for 5 cycles in OUT. o_valid and o_e are held, i_valid is refused (o_ready=0), and the transfer completes on the 6th cycle.
- wb_rst_n pulsed low mid-cycle in POLL_OUT: cyc/stb=0 asynchronously, all outputs return to their reset values, and the next i_seq runs the full sequence normally.
- i_cfg and i_valid asserted together in IDLE: the CTRL write happens first, then the sequence is accepted on return to IDLE.
